// File: rtl/pixel_stream_sink.sv
`default_nettype none
// ============================================================================
// Module      : pixel_stream_sink
// Description : Tile-draw pixel stream sink. Buffers (x,y,colour) plot requests,
//               issues framebuffer writes at y*SCREEN_W+x, and counts finished
//               tiles. Optional clipping is enabled by PIXEL_SINK_CLIP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_stream_sink #(
    parameter int DEPTH    = 16,
    parameter int TILE_PIX = 400,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pix_valid,
    input  logic [7:0]  pix_x,
    input  logic [6:0]  pix_y,
    input  logic [2:0]  pix_colour,
    output logic        pix_ready,
    output logic        fb_we,
    output logic [14:0] fb_addr,
    output logic [2:0]  fb_data,
    input  logic        fb_ready,
    output logic [4:0]  fifo_level,
    output logic        tile_done,
    output logic [7:0]  drop_count
);

    localparam int c_PTR_W  = $clog2(DEPTH);
    localparam int c_TILE_W = $clog2(TILE_PIX);
    localparam int c_SUM_W  = c_TILE_W + 1;
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = 1;

    logic [17:0]          r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [4:0]           r_level;
    logic                 r_pix_ready;
    logic                 r_fb_we;
    logic [14:0]          r_fb_addr;
    logic [2:0]           r_fb_data;
    logic [c_TILE_W-1:0]  r_tile_cnt;
    logic                 r_tile_done;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_clip;
    logic [17:0]          w_head;
    logic [7:0]           w_head_x;
    logic [6:0]           w_head_y;
    logic [2:0]           w_head_c;
    logic [14:0]          w_head_addr;
    logic [4:0]           w_level_next;
    logic [1:0]           w_retire_cnt;
    logic [c_SUM_W-1:0]   w_tile_sum;
    logic                 w_tile_wrap;
    logic [c_SUM_W-1:0]   w_tile_next;

    assign w_push      = pix_valid & r_pix_ready;
    assign w_pop       = (~r_fb_we | fb_ready) & (r_level != 5'd0);
    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_x    = w_head[17:10];
    assign w_head_y    = w_head[9:3];
    assign w_head_c    = w_head[2:0];
    assign w_head_addr = 15'(w_head_y) * 15'(SCREEN_W) + 15'(w_head_x);

`ifdef PIXEL_SINK_CLIP_EN
    assign w_clip = (32'(w_head_x) >= SCREEN_W) || (32'(w_head_y) >= SCREEN_H);
`else
    assign w_clip = 1'b0;
`endif

    always_comb begin
        w_level_next = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_next = r_level + 5'd1;
            2'b01:   w_level_next = r_level - 5'd1;
            default: w_level_next = r_level;
        endcase
    end

    // A retire is an accepted write and/or a clipped pop; both can occur in one cycle.
    assign w_retire_cnt = {1'b0, r_fb_we & fb_ready} + {1'b0, w_pop & w_clip};
    assign w_tile_sum   = {1'b0, r_tile_cnt} + c_SUM_W'(w_retire_cnt);
    assign w_tile_wrap  = (w_tile_sum >= c_SUM_W'(TILE_PIX));
    assign w_tile_next  = w_tile_wrap ? (w_tile_sum - c_SUM_W'(TILE_PIX)) : w_tile_sum;

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {pix_x, pix_y, pix_colour};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= 5'd0;
            r_pix_ready <= 1'b1;
            r_fb_we     <= 1'b0;
            r_fb_addr   <= 15'd0;
            r_fb_data   <= 3'd0;
            r_tile_cnt  <= '0;
            r_tile_done <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_level     <= w_level_next;
            r_pix_ready <= (w_level_next != 5'(DEPTH));
            if (w_pop) begin
                r_fb_we <= ~w_clip;
                if (!w_clip) begin
                    r_fb_addr <= w_head_addr;
                    r_fb_data <= w_head_c;
                end
            end else if (fb_ready) begin
                r_fb_we <= 1'b0;
            end
            r_tile_cnt  <= w_tile_next[c_TILE_W-1:0];
            r_tile_done <= w_tile_wrap;
        end
    end

`ifdef PIXEL_SINK_CLIP_EN
    logic [7:0] r_drop_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_drop_count <= 8'd0;
        end else if (w_pop && w_clip && (r_drop_count != 8'hFF)) begin
            r_drop_count <= r_drop_count + 8'd1;
        end
    end

    assign drop_count = r_drop_count;
`else
    assign drop_count = 8'd0;
`endif

    assign pix_ready  = r_pix_ready;
    assign fb_we      = r_fb_we;
    assign fb_addr    = r_fb_addr;
    assign fb_data    = r_fb_data;
    assign fifo_level = r_level;
    assign tile_done  = r_tile_done;

endmodule
`default_nettype wire

// File: tb/tb_pixel_stream_sink.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_stream_sink
// Description : Self-checking bench for pixel_stream_sink (directed vectors plus
//               an in-order write model); clip cases need PIXEL_SINK_CLIP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_stream_sink;

    localparam int c_W    = 160;
    localparam int c_H    = 120;
    localparam int c_TILE = 400;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        pix_valid = 1'b0;
    logic [7:0]  pix_x = 8'd0;
    logic [6:0]  pix_y = 7'd0;
    logic [2:0]  pix_colour = 3'd0;
    logic        pix_ready;
    logic        fb_we;
    logic [14:0] fb_addr;
    logic [2:0]  fb_data;
    logic        fb_ready = 1'b0;
    logic [4:0]  fifo_level;
    logic        tile_done;
    logic [7:0]  drop_count;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];
    int  m_tile = 0;
    bit  m_done_next = 1'b0;
    bit  held_valid = 1'b0;
    int  held_addr = 0;
    int  held_data = 0;
    int  n_writes = 0;
    int  n_tile_pulses = 0;

    pixel_stream_sink dut (
        .clock      (clock),
        .reset      (reset),
        .pix_valid  (pix_valid),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_colour (pix_colour),
        .pix_ready  (pix_ready),
        .fb_we      (fb_we),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .fb_ready   (fb_ready),
        .fifo_level (fifo_level),
        .tile_done  (tile_done),
        .drop_count (drop_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: every accepted in-range pixel becomes one write, in order, at y*W+x.
    always @(negedge clock) begin
        if (reset) begin
            check("rst_fb_we", fb_we, 0);
            check("rst_pix_ready", pix_ready, 1);
            check("rst_level", fifo_level, 0);
            check("rst_tile_done", tile_done, 0);
            check("rst_drop", drop_count, 0);
            check("rst_addr", fb_addr, 0);
            exp_q.delete();
            m_tile = 0;
            m_done_next = 1'b0;
            held_valid = 1'b0;
            n_writes = 0;
            n_tile_pulses = 0;
        end else begin
            check("tile_done", tile_done, m_done_next);
            if (tile_done) n_tile_pulses++;
            m_done_next = 1'b0;
            check("ready_vs_level", pix_ready, (fifo_level != 5'd16));
            if (held_valid) begin
                check("hold_we", fb_we, 1);
                check("hold_addr", fb_addr, held_addr);
                check("hold_data", fb_data, held_data);
            end
            held_valid = fb_we && !fb_ready;
            held_addr  = fb_addr;
            held_data  = fb_data;
            if (fb_we && fb_ready) begin
                n_writes++;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", fb_addr, 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", fb_addr, e.addr);
                    check("wr_data", fb_data, e.data);
                end
                m_tile++;
                if (m_tile == c_TILE) begin
                    m_tile = 0;
                    m_done_next = 1'b1;
                end
            end
            if (pix_valid && pix_ready) begin
                wr_t e;
                bit  clipped;
                clipped = 1'b0;
`ifdef PIXEL_SINK_CLIP_EN
                clipped = (int'(pix_x) >= c_W) || (int'(pix_y) >= c_H);
`endif
                e.addr = (int'(pix_y) * c_W + int'(pix_x)) % 32768;
                e.data = int'(pix_colour);
                if (!clipped) exp_q.push_back(e);
            end
        end
    end

    task automatic push(input int x, input int y, input int c);
        bit ok;
        int t;
        t = 0;
        pix_x      = x[7:0];
        pix_y      = y[6:0];
        pix_colour = c[2:0];
        pix_valid  = 1'b1;
        do begin
            ok = pix_ready;
            @(posedge clock);
            #1;
            t++;
        end while (!ok && t < 50);
        pix_valid = 1'b0;
        if (!ok) check("push_timeout", 0, 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int run;

        // 1: single pixel, one-cycle latency to fb_we
        tick(1);
        do_reset();
        fb_ready = 1'b1;
        push(20, 40, 5);
        check("t1_we_before", fb_we, 0);
        tick(1);
        check("t1_we", fb_we, 1);
        check("t1_addr", fb_addr, 6420);
        check("t1_data", fb_data, 5);
        tick(1);
        check("t1_we_after", fb_we, 0);

        // 2: back-pressure, full FIFO plus held output, then drain
        do_reset();
        fb_ready = 1'b0;
        for (int i = 0; i < 17; i++) push(i, i + 1, i % 8);
        check("t2_ready", pix_ready, 0);
        check("t2_level", fifo_level, 16);
        check("t2_we", fb_we, 1);
        check("t2_addr", fb_addr, 160);
        tick(3);
        check("t2_ready_hold", pix_ready, 0);
        fb_ready = 1'b1;
        run = 0;
        while (fb_we && run < 30) begin
            run++;
            tick(1);
        end
        check("t2_run", run, 17);
        check("t2_level_end", fifo_level, 0);

        // 3: full 20x20 tile at (60,20)
        do_reset();
        fb_ready = 1'b1;
        for (int i = 0; i < c_TILE; i++) begin
            push(60 + i % 20, 20 + i / 20, i % 8);
            if (i == 1) check("t3_first_addr", fb_addr, 3260);
        end
        tick(10);
        check("t3_writes", n_writes, 400);
        check("t3_pulses", n_tile_pulses, 1);

`ifdef PIXEL_SINK_CLIP_EN
        // 4: clipping
        do_reset();
        fb_ready = 1'b1;
        push(170, 10, 1);
        push(10, 125, 2);
        push(0, 0, 3);
        tick(5);
        check("t4_drop", drop_count, 2);
        check("t4_writes", n_writes, 1);
        check("t4_tile_pulses", n_tile_pulses, 0);
`else
        // 5: out-of-range pixel is written raw
        do_reset();
        fb_ready = 1'b1;
        push(170, 10, 6);
        tick(1);
        check("t5_we", fb_we, 1);
        check("t5_addr", fb_addr, 1770);
        check("t5_data", fb_data, 6);
        check("t5_drop", drop_count, 0);
        tick(2);
`endif

        // 6: asynchronous reset mid-transfer
        do_reset();
        fb_ready = 1'b0;
        for (int i = 0; i < 9; i++) push(i + 3, 2, i % 8);
        check("t6_level", fifo_level, 8);
        check("t6_we", fb_we, 1);
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_we", fb_we, 0);
        check("t6_async_level", fifo_level, 0);
        check("t6_async_ready", pix_ready, 1);
        check("t6_async_addr", fb_addr, 0);
        check("t6_async_data", fb_data, 0);
        tick(2);
        reset = 1'b0;
        fb_ready = 1'b1;
        tick(10);
        check("t6_no_writes", n_writes, 0);
        check("t6_idle_we", fb_we, 0);
        push(5, 5, 3);
        tick(1);
        check("t6_new_we", fb_we, 1);
        check("t6_new_addr", fb_addr, 805);
        tick(3);
        check("t6_new_writes", n_writes, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
